// File: rtl/jop_alarm_pkg.sv
// Shared types and default sizing for the JOP alarm controller.
package jop_alarm_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        WARN   = 2'd1,
        ALARM  = 2'd2,
        CLEAR  = 2'd3
    } alarm_state_e;

    localparam int unsigned DefWidth      = 8;
    localparam int unsigned DefNumSrc     = 4;
    localparam int unsigned DefLeakPeriod = 256;

endpackage

// File: rtl/jop_alarm_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins (purely combinational).
module jop_alarm_rr_arb
    import jop_alarm_pkg::*;
#(
    parameter  int unsigned N    = DefNumSrc,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt_c,
    output logic [IdxW-1:0] idx_c,
    output logic            vld_c
);

    // Scan requesters starting at ptr, wrapping modulo N.
    always_comb begin
        int unsigned    j;
        logic [IdxW-1:0] jj;
        j     = 0;
        jj    = '0;
        gnt_c = '0;
        idx_c = '0;
        vld_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            j  = (32'(ptr) + i) % N;
            jj = IdxW'(j);
            if (!vld_c && req[jj]) begin
                vld_c     = 1'b1;
                gnt_c[jj] = 1'b1;
                idx_c     = jj;
            end
        end
    end

endmodule

// File: rtl/jop_alarm_ctrl.sv
// JOP alarm controller: arbitrates score commands, runs the sticky alarm FSM and
// the clear handshake. Optional periodic leak enabled by defining JOP_ALARM_LEAK_EN.
module jop_alarm_ctrl
    import jop_alarm_pkg::*;
#(
    parameter int unsigned Width      = DefWidth,
    parameter int unsigned NumSrc     = DefNumSrc,
    parameter int unsigned LeakPeriod = DefLeakPeriod
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumSrc-1:0]       evt_i,
    input  logic                    good_i,
    input  logic [NumSrc*Width-1:0] cfg_step_i,
    input  logic [Width-1:0]        cfg_warn_i,
    input  logic [Width-1:0]        cfg_alarm_i,
    input  logic                    leak_en_i,
    input  logic                    clr_req_i,
    output logic                    clr_ack_o,
    input  logic [Width-1:0]        cnt_i,
    output logic                    cnt_incr_o,
    output logic                    cnt_decr_o,
    output logic [Width-1:0]        cnt_step_o,
    output logic                    warn_o,
    output logic                    alarm_o,
    output logic                    drop_o
);

    localparam int unsigned IdxW  = $clog2(NumSrc);
    localparam int unsigned LeakW = $clog2(LeakPeriod);

    alarm_state_e      state_q;
    logic [NumSrc-1:0] pend_q;
    logic              good_q;
    logic [IdxW-1:0]   ptr_q;
    logic              leak_q;

    logic [NumSrc-1:0] arb_gnt;
    logic [IdxW-1:0]   arb_idx;
    logic              arb_vld;
    logic              active_c;
    logic              leak_gnt_c;
    logic [Width-1:0]  step_sel_c;
    logic [IdxW-1:0]   ptr_nxt_c;

    jop_alarm_rr_arb #(.N(NumSrc)) u_arb (
        .req   (pend_q),
        .ptr   (ptr_q),
        .gnt_c (arb_gnt),
        .idx_c (arb_idx),
        .vld_c (arb_vld)
    );

    // Leak is lowest priority: only granted when no source and no benign event waits.
    assign active_c   = (state_q != CLEAR);
    assign leak_gnt_c = active_c && !arb_vld && !good_q && leak_q;
    assign step_sel_c = cfg_step_i[arb_idx*Width +: Width];
    assign ptr_nxt_c  = (arb_idx == IdxW'(NumSrc - 1)) ? '0 : arb_idx + IdxW'(1);

`ifdef JOP_ALARM_LEAK_EN
    logic [LeakW-1:0] leak_tmr_q;
    logic             leak_wrap_c;

    assign leak_wrap_c = (leak_tmr_q == LeakW'(LeakPeriod - 1));

    // Leak timer; a wrap while leak_q is still set merges into the pending leak.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            leak_tmr_q <= '0;
            leak_q     <= 1'b0;
        end else if (!leak_en_i) begin
            leak_tmr_q <= '0;
            leak_q     <= 1'b0;
        end else begin
            leak_tmr_q <= leak_wrap_c ? '0 : leak_tmr_q + LeakW'(1);
            leak_q     <= active_c && ((leak_q && !leak_gnt_c) || leak_wrap_c);
        end
    end
`else
    logic [LeakW+1:0] unused_leak;

    assign leak_q      = 1'b0;
    assign unused_leak = {leak_en_i, leak_gnt_c, LeakW'(0)};
`endif

    // Pending capture, command issue and alarm FSM; all commands leave registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= NORMAL;
            pend_q     <= '0;
            good_q     <= 1'b0;
            ptr_q      <= '0;
            drop_o     <= 1'b0;
            cnt_incr_o <= 1'b0;
            cnt_decr_o <= 1'b0;
            cnt_step_o <= '0;
            clr_ack_o  <= 1'b0;
        end else begin
            cnt_incr_o <= 1'b0;
            cnt_decr_o <= 1'b0;
            cnt_step_o <= '0;
            clr_ack_o  <= 1'b0;
            if (state_q == CLEAR) begin
                pend_q <= '0;
                good_q <= 1'b0;
                drop_o <= 1'b0;
                if (cnt_i != '0) begin
                    cnt_decr_o <= 1'b1;
                    cnt_step_o <= '1;
                end else begin
                    clr_ack_o <= 1'b1;
                    state_q   <= NORMAL;
                end
            end else begin
                if (arb_vld) begin
                    cnt_incr_o <= 1'b1;
                    cnt_step_o <= step_sel_c;
                    ptr_q      <= ptr_nxt_c;
                end else if (good_q || leak_q) begin
                    cnt_decr_o <= 1'b1;
                    cnt_step_o <= Width'(1);
                end
                pend_q <= (pend_q & ~arb_gnt) | evt_i;
                good_q <= (good_q & arb_vld) | good_i;
                if ((evt_i & pend_q & ~arb_gnt) != '0) begin
                    drop_o <= 1'b1;
                end
                case (state_q)
                    NORMAL: begin
                        if (cnt_i >= cfg_alarm_i)     state_q <= ALARM;
                        else if (cnt_i >= cfg_warn_i) state_q <= WARN;
                    end
                    WARN: begin
                        if (cnt_i >= cfg_alarm_i)    state_q <= ALARM;
                        else if (cnt_i < cfg_warn_i) state_q <= NORMAL;
                    end
                    ALARM: begin
                        if (clr_req_i) state_q <= CLEAR;
                    end
                    default: ;
                endcase
                // Outside ALARM a clear request is simply acknowledged once.
                if (clr_req_i && !clr_ack_o && (state_q != ALARM)) begin
                    clr_ack_o <= 1'b1;
                end
            end
        end
    end

    assign warn_o  = (state_q == WARN);
    assign alarm_o = (state_q == ALARM) || (state_q == CLEAR);

endmodule

// File: tb/tb_jop_alarm_ctrl.sv
// Bench for jop_alarm_ctrl with a saturating score counter alongside it.
module tb_jop_alarm_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned NS = 4;
    localparam int unsigned LP = 16;

    typedef struct packed {
        logic       incr;
        logic       decr;
        logic [7:0] step;
    } cmd_t;

    typedef struct {
        logic [3:0]  evt;
        logic        good;
        logic [31:0] steps;
        logic [7:0]  exp_cnt;
        logic        exp_warn;
        logic        exp_alarm;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] evt = '0;
    logic          good = 1'b0;
    logic [31:0]   cfg_step = '0;
    logic [W-1:0]  cfg_warn = 8'd8;
    logic [W-1:0]  cfg_alarm = 8'd20;
    logic          leak_en = 1'b0;
    logic          clr_req = 1'b0;
    logic          clr_ack;
    logic [W-1:0]  cnt;
    logic          cnt_incr;
    logic          cnt_decr;
    logic [W-1:0]  cnt_step;
    logic          warn;
    logic          alarm;
    logic          drop;

    int   total = 0;
    int   bad = 0;
    bit   sb_on = 1'b0;
    cmd_t sb_q[$];
    vec_t vecs[10];
    int   nd;
    int   last;
    bit   got_ack;
    bit   saw_incr;

    jop_alarm_ctrl #(.Width(W), .NumSrc(NS), .LeakPeriod(LP)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .evt_i       (evt),
        .good_i      (good),
        .cfg_step_i  (cfg_step),
        .cfg_warn_i  (cfg_warn),
        .cfg_alarm_i (cfg_alarm),
        .leak_en_i   (leak_en),
        .clr_req_i   (clr_req),
        .clr_ack_o   (clr_ack),
        .cnt_i       (cnt),
        .cnt_incr_o  (cnt_incr),
        .cnt_decr_o  (cnt_decr),
        .cnt_step_o  (cnt_step),
        .warn_o      (warn),
        .alarm_o     (alarm),
        .drop_o      (drop)
    );

    always #5 clk = ~clk;

    // Saturating score counter fed by the controller commands.
    logic [W:0] sum;
    assign sum = {1'b0, cnt} + {1'b0, cnt_step};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (cnt_incr) cnt <= sum[W] ? '1 : sum[W-1:0];
        else if (cnt_decr) cnt <= (cnt < cnt_step) ? '0 : cnt - cnt_step;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic exp_cmd(input logic inc, input logic [7:0] st);
        cmd_t c;
        c.incr = inc;
        c.decr = ~inc;
        c.step = st;
        sb_q.push_back(c);
    endtask

    task automatic pulse(input logic [3:0] e, input logic g);
        @(negedge clk);
        evt  = e;
        good = g;
        @(posedge clk);
        #1;
        evt  = '0;
        good = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", 32'({cnt_incr, cnt_decr, cnt_step, warn, alarm, drop, clr_ack}), 0);
        chk("rst_cnt", 32'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every issued command must match the next expected one.
    always @(negedge clk) begin
        cmd_t e;
        if (rst_n && sb_on && (cnt_incr || cnt_decr)) begin
            chk("cmd_excl", 32'(cnt_incr & cnt_decr), 0);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'({cnt_incr, cnt_decr, cnt_step}), 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_cmd", 32'({cnt_incr, cnt_decr, cnt_step}), 32'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0001, 1'b0, 32'h0000_0005, 8'd5,   1'b0, 1'b0};
        vecs[1] = '{4'b0011, 1'b0, 32'h0000_0405, 8'd9,   1'b1, 1'b0};
        vecs[2] = '{4'b1111, 1'b0, 32'h0403_0201, 8'd10,  1'b1, 1'b0};
        vecs[3] = '{4'b1100, 1'b0, 32'h0C0A_0000, 8'd22,  1'b0, 1'b1};
        vecs[4] = '{4'b0100, 1'b0, 32'h0008_0000, 8'd8,   1'b1, 1'b0};
        vecs[5] = '{4'b0010, 1'b0, 32'h0000_1400, 8'd20,  1'b0, 1'b1};
        vecs[6] = '{4'b0001, 1'b0, 32'h0000_0007, 8'd7,   1'b0, 1'b0};
        vecs[7] = '{4'b1001, 1'b0, 32'h6400_00C8, 8'd255, 1'b0, 1'b1};
        vecs[8] = '{4'b0001, 1'b1, 32'h0000_0000, 8'd0,   1'b0, 1'b0};
        vecs[9] = '{4'b0010, 1'b1, 32'h0000_0300, 8'd2,   1'b0, 1'b0};

        // Reset and idle.
        do_reset();
        sb_on = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_cnt", 32'(cnt), 0);
        chk("idle_state", 32'({warn, alarm, drop}), 0);

        // Table of single-pulse vectors, each from reset.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            cfg_step = vecs[i].steps;
            for (int k = 0; k < 4; k++)
                if (vecs[i].evt[k]) exp_cmd(1'b1, vecs[i].steps[k*8 +: 8]);
            if (vecs[i].good) exp_cmd(1'b0, 8'd1);
            pulse(vecs[i].evt, vecs[i].good);
            repeat (10) @(negedge clk);
            chk("vec_cnt", 32'(cnt), 32'(vecs[i].exp_cnt));
            chk("vec_warn", 32'(warn), 32'(vecs[i].exp_warn));
            chk("vec_alarm", 32'(alarm), 32'(vecs[i].exp_alarm));
            chk("vec_drop", 32'(drop), 0);
            chk("vec_sb_left", 32'(sb_q.size()), 0);
        end

        // Latency into WARN and ALARM.
        do_reset();
        cfg_step = 32'h0000_000A;
        exp_cmd(1'b1, 8'd10);
        pulse(4'b0001, 1'b0);
        @(negedge clk);
        chk("lat_incr_n0", 32'(cnt_incr), 0);
        @(negedge clk);
        chk("lat_incr_n1", 32'(cnt_incr), 1);
        @(negedge clk);
        chk("lat_cnt_n2", 32'(cnt), 10);
        chk("lat_warn_n2", 32'(warn), 0);
        @(negedge clk);
        chk("lat_warn_n3", 32'(warn), 1);
        exp_cmd(1'b1, 8'd10);
        pulse(4'b0001, 1'b0);
        repeat (3) @(negedge clk);
        chk("lat_cnt_m2", 32'(cnt), 20);
        chk("lat_alarm_m2", 32'(alarm), 0);
        @(negedge clk);
        chk("lat_alarm_m3", 32'(alarm), 1);
        chk("lat_warn_m3", 32'(warn), 0);

        // Clear from ALARM; an event during CLEAR is ignored.
        sb_on    = 1'b0;
        got_ack  = 1'b0;
        saw_incr = 1'b0;
        @(negedge clk);
        clr_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("clr_alarm_hold", 32'(alarm), 1);
                evt = 4'b0001;
            end
            if (i == 1) evt = '0;
            if (cnt_incr) saw_incr = 1'b1;
            if (clr_ack) begin
                got_ack = 1'b1;
                break;
            end
        end
        evt = '0;
        chk("clr_ack_seen", 32'(got_ack), 1);
        chk("clr_no_incr", 32'(saw_incr), 0);
        chk("clr_cnt", 32'(cnt), 0);
        chk("clr_outs", 32'({warn, alarm, drop}), 0);
        @(negedge clk);
        chk("clr_ack_once", 32'(clr_ack), 0);
        clr_req = 1'b0;
        sb_on   = 1'b1;
        repeat (6) @(negedge clk);
        chk("clr_cnt_after", 32'(cnt), 0);
        chk("clr_state_after", 32'({warn, alarm}), 0);

        // Clear request in NORMAL: one ack, no state change.
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        chk("nclr_ack", 32'(clr_ack), 1);
        chk("nclr_state", 32'({warn, alarm}), 0);
        @(negedge clk);
        chk("nclr_ack_once", 32'(clr_ack), 0);
        clr_req = 1'b0;
        @(negedge clk);
        chk("nclr_ack_idle", 32'(clr_ack), 0);

        // Drop on repeat event, then good+evt ordering, then round-robin rotation.
        do_reset();
        cfg_step = 32'h0403_0201;
        exp_cmd(1'b1, 8'd1);
        exp_cmd(1'b1, 8'd2);
        exp_cmd(1'b1, 8'd3);
        @(negedge clk);
        evt = 4'b0011;
        @(negedge clk);
        evt = 4'b0100;
        chk("drop_a0", 32'(drop), 0);
        @(negedge clk);
        chk("drop_a1", 32'(drop), 0);
        @(negedge clk);
        evt = '0;
        chk("drop_a2", 32'(drop), 1);
        repeat (6) @(negedge clk);
        chk("drop_cnt", 32'(cnt), 6);
        chk("drop_sticky", 32'(drop), 1);
        exp_cmd(1'b1, 8'd1);
        exp_cmd(1'b0, 8'd1);
        pulse(4'b0001, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("ge_incr_first", 32'({cnt_incr, cnt_decr}), 32'(2'b10));
        @(negedge clk);
        chk("ge_decr_next", 32'({cnt_incr, cnt_decr}), 32'(2'b01));
        repeat (4) @(negedge clk);
        chk("ge_cnt", 32'(cnt), 6);
        exp_cmd(1'b1, 8'd3);
        exp_cmd(1'b1, 8'd1);
        pulse(4'b0101, 1'b0);
        repeat (6) @(negedge clk);
        chk("rr_cnt", 32'(cnt), 10);
        chk("rr_sb_left", 32'(sb_q.size()), 0);

        // Async reset while commands are in flight.
        sb_on = 1'b0;
        cfg_step = 32'h0403_0201;
        pulse(4'b1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_incr_before", 32'(cnt_incr), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({cnt_incr, cnt_decr, cnt_step, warn, alarm, drop, clr_ack}), 0);
        chk("mid_rst_cnt", 32'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        sb_on = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_cnt_after", 32'(cnt), 0);

        // Leak behaviour.
        do_reset();
        cfg_step = 32'h0000_0003;
        exp_cmd(1'b1, 8'd3);
        pulse(4'b0001, 1'b0);
        repeat (5) @(negedge clk);
        chk("leak_pre_cnt", 32'(cnt), 3);
`ifdef JOP_ALARM_LEAK_EN
        sb_on = 1'b0;
        leak_en = 1'b1;
        nd = 0;
        last = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (cnt_decr) begin
                if (nd > 0) chk("leak_period", 32'(c - last), 16);
                else        chk("leak_first", 32'(c), 16);
                chk("leak_step", 32'({cnt_incr, cnt_step}), 1);
                last = c;
                nd++;
            end
        end
        chk("leak_num", 32'(nd), 4);
        chk("leak_cnt", 32'(cnt), 0);
        leak_en = 1'b0;
        repeat (2) @(negedge clk);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cnt_decr) nd++;
        end
        chk("leak_off_num", 32'(nd), 0);
`else
        leak_en = 1'b1;
        repeat (70) @(negedge clk);
        chk("noleak_cnt", 32'(cnt), 3);
        leak_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
